// File: rtl/tone_seq_pkg.sv
// Shared constants and state encoding for the tone sequencer.
// The one-shot vs. looping playback choice is made by TONE_SEQ_LOOP_EN in tone_sequencer.
package tone_seq_pkg;

  typedef enum logic {
    PAUSED  = 1'b0,
    PLAYING = 1'b1
  } seq_state_e;

  localparam int unsigned CYCLES_PER_MS   = 125000;
  localparam int unsigned TEMPO_DEFAULT_C = 200 * CYCLES_PER_MS;
  localparam int unsigned TEMPO_STEP_C    = 8 * CYCLES_PER_MS;
  localparam int unsigned TEMPO_MIN_C     = 16 * CYCLES_PER_MS;
  localparam int unsigned TEMPO_MAX_C     = 800 * CYCLES_PER_MS;

endpackage

// File: rtl/tone_sequencer_tempo_ctrl.sv
// Saturating tempo register, in cycles per note, nudged by single-cycle up/down pulses.
// Up and down together cancel; the result is always clamped to [TEMPO_MIN, TEMPO_MAX].
module tempo_ctrl
  import tone_seq_pkg::*;
#(
  parameter int unsigned TEMPO_W       = 32,
  parameter int unsigned TEMPO_DEFAULT = TEMPO_DEFAULT_C,
  parameter int unsigned TEMPO_STEP    = TEMPO_STEP_C,
  parameter int unsigned TEMPO_MIN     = TEMPO_MIN_C,
  parameter int unsigned TEMPO_MAX     = TEMPO_MAX_C
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tempo_up,
  input  logic               tempo_down,
  output logic [TEMPO_W-1:0] tempo
);

  localparam logic [TEMPO_W-1:0] DEF_V  = TEMPO_W'(TEMPO_DEFAULT);
  localparam logic [TEMPO_W-1:0] STEP_V = TEMPO_W'(TEMPO_STEP);
  localparam logic [TEMPO_W-1:0] MIN_V  = TEMPO_W'(TEMPO_MIN);
  localparam logic [TEMPO_W-1:0] MAX_V  = TEMPO_W'(TEMPO_MAX);

  logic [TEMPO_W-1:0] tempo_q, tempo_d;

  // Compare against the bound minus/plus one step so the add/subtract can never wrap.
  always_comb begin
    tempo_d = tempo_q;
    if (tempo_up && !tempo_down) begin
      tempo_d = (tempo_q >= MAX_V - STEP_V) ? MAX_V : tempo_q + STEP_V;
    end else if (tempo_down && !tempo_up) begin
      tempo_d = (tempo_q <= MIN_V + STEP_V) ? MIN_V : tempo_q - STEP_V;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) tempo_q <= DEF_V;
    else     tempo_q <= tempo_d;
  end

  assign tempo = tempo_q;

endmodule

// File: rtl/tone_sequencer.sv
// Steps through the note ROM at a programmable tempo and feeds the tone generator.
// Build option TONE_SEQ_LOOP_EN: defined = continuous wrap-around, undefined = one-shot playback.
//
//   state   | meaning
//   PAUSED  | note_cnt and rom_addr hold, tone_period forced to 0
//   PLAYING | note_cnt counts up, rom_addr steps at each note boundary
module tone_sequencer
  import tone_seq_pkg::*;
#(
  parameter int unsigned ADDR_W        = 10,
  parameter int unsigned PERIOD_W      = 24,
  parameter int unsigned LAST_ADDR     = 1023,
  parameter int unsigned TEMPO_W       = 32,
  parameter int unsigned TEMPO_DEFAULT = TEMPO_DEFAULT_C,
  parameter int unsigned TEMPO_STEP    = TEMPO_STEP_C,
  parameter int unsigned TEMPO_MIN     = TEMPO_MIN_C,
  parameter int unsigned TEMPO_MAX     = TEMPO_MAX_C
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                play_pause,
  input  logic                reverse,
  input  logic                tempo_up,
  input  logic                tempo_down,
  output logic [ADDR_W-1:0]   rom_addr,
  input  logic [PERIOD_W-1:0] rom_data,
  output logic [PERIOD_W-1:0] tone_period,
  output logic                playing,
  output logic                dir_rev
);

`ifdef TONE_SEQ_LOOP_EN
  localparam bit LOOP_EN = 1'b1;
`else
  localparam bit LOOP_EN = 1'b0;
`endif

  localparam logic [ADDR_W-1:0]  LAST_V   = ADDR_W'(LAST_ADDR);
  localparam logic [ADDR_W-1:0]  ADDR_ONE = ADDR_W'(1);
  localparam logic [TEMPO_W-1:0] CNT_ONE  = TEMPO_W'(1);

  seq_state_e          state_q, state_d;
  logic                dir_q, dir_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [TEMPO_W-1:0]  cnt_q, cnt_d;
  logic [PERIOD_W-1:0] tone_q, tone_d;
  logic [TEMPO_W-1:0]  tempo;
  logic                at_boundary;

  tempo_ctrl #(
    .TEMPO_W      (TEMPO_W),
    .TEMPO_DEFAULT(TEMPO_DEFAULT),
    .TEMPO_STEP   (TEMPO_STEP),
    .TEMPO_MIN    (TEMPO_MIN),
    .TEMPO_MAX    (TEMPO_MAX)
  ) u_tempo (
    .clk       (clk),
    .rst       (rst),
    .tempo_up  (tempo_up),
    .tempo_down(tempo_down),
    .tempo     (tempo)
  );

  // tempo never drops below TEMPO_MIN, so tempo-1 cannot underflow; >= catches a shrunk tempo.
  assign at_boundary = (cnt_q >= tempo - CNT_ONE);

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q ^ reverse;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    tone_d  = (state_q == PLAYING) ? rom_data : '0;
    case (state_q)
      PAUSED: begin
        if (play_pause) state_d = PLAYING;
      end
      PLAYING: begin
        if (play_pause) begin
          state_d = PAUSED;
        end else if (at_boundary) begin
          cnt_d = '0;
          // A reverse pulse on the boundary cycle already steers this step (dir_d, not dir_q).
          if (!dir_d) begin
            if (addr_q == LAST_V) begin
              addr_d = '0;
              if (!LOOP_EN) state_d = PAUSED;
            end else begin
              addr_d = addr_q + ADDR_ONE;
            end
          end else begin
            if (addr_q == '0) begin
              addr_d = LAST_V;
              if (!LOOP_EN) state_d = PAUSED;
            end else begin
              addr_d = addr_q - ADDR_ONE;
            end
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: state_d = PAUSED;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= PAUSED;
      dir_q   <= 1'b0;
      addr_q  <= '0;
      cnt_q   <= '0;
      tone_q  <= '0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      tone_q  <= tone_d;
    end
  end

  assign rom_addr    = addr_q;
  assign tone_period = tone_q;
  assign playing     = (state_q == PLAYING);
  assign dir_rev     = dir_q;

endmodule

// File: doc/tone_sequencer.md
Name: tone_sequencer

Overview:
- Controller that sequences the audio tone datapath: steps through a note ROM and drives the tone period into the PWM tone generator.
- Each ROM entry is held for a programmable tempo, measured in clock cycles.
- Supports play/pause, forward/reverse direction and tempo adjust from debounced single-cycle button pulses.
- Sits between the button conditioner and the tone generator inside z1top.

Parameters:
- ADDR_W, 10, ROM address width.
- PERIOD_W, 24, tone period width in clocks.
- LAST_ADDR, 1023, final ROM index used.
- TEMPO_W, 32, tempo register width.
- TEMPO_DEFAULT, 25000000, cycles per note after reset (200 ms at 125 MHz).
- TEMPO_STEP, 1000000, tempo change per tempo_up/tempo_down pulse.
- TEMPO_MIN, 2000000, tempo floor.
- TEMPO_MAX, 100000000, tempo ceiling.

Ports:
- clk  in  1  system clock, 125 MHz.
- rst  in  1  asynchronous, active-high reset.
- play_pause  in  1  one-cycle pulse; toggles PAUSED/PLAYING.
- reverse  in  1  one-cycle pulse; toggles direction.
- tempo_up  in  1  one-cycle pulse; slows playback, tempo += TEMPO_STEP.
- tempo_down  in  1  one-cycle pulse; speeds playback, tempo -= TEMPO_STEP.
- rom_addr  out  ADDR_W  registered ROM address.
- rom_data  in  PERIOD_W  synchronous ROM output; valid one cycle after rom_addr.
- tone_period  out  PERIOD_W  period to the tone generator; 0 = silence.
- playing  out  1  1 when in PLAYING.
- dir_rev  out  1  1 when direction is reverse.

Behaviour:
- Reset (async, rst=1) values:
  - state PAUSED, dir_rev=0.
  - rom_addr=0, note_cnt=0, tempo=TEMPO_DEFAULT.
  - tone_period=0, playing=0.
- States:
  - PAUSED: note_cnt and rom_addr hold; play_pause goes to PLAYING.
  - PLAYING: note_cnt increments each cycle; play_pause goes to PAUSED.
- Note boundary: PLAYING and note_cnt >= tempo-1. On that cycle:
  - note_cnt <= 0.
  - rom_addr steps +1 (forward) or -1 (reverse).
- Wrap (loop build):
  - forward at LAST_ADDR goes to 0.
  - reverse at 0 goes to LAST_ADDR.
- The >= comparison means a tempo reduced below the current note_cnt causes an advance on the next cycle; note_cnt never runs away.
- tone_period register, updated every cycle:
  - PLAYING: tone_period <= rom_data.
  - PAUSED: tone_period <= 0.
  - Net latency: rom_addr change to tone_period update is 2 cycles; play_pause pulse to tone_period nonzero is 2 cycles.
  - rom_data==0 is a rest and passes through as 0.
- Tempo:
  - Saturating, clamped to [TEMPO_MIN, TEMPO_MAX].
  - tempo_up and tempo_down in the same cycle: no change.
  - A tempo change does not reset note_cnt.
- Simultaneous events:
  - play_pause coinciding with a note boundary: pause wins; rom_addr and note_cnt hold.
  - reverse coinciding with a boundary: the new direction applies to that step.
  - reverse while PAUSED toggles direction only.
- Reset mid-note: all state returns to reset values immediately (async); tone_period goes to 0 the same instant.

Optional Feature:
- Macro: TONE_SEQ_LOOP_EN.
- Defined: wrap-around as above; playback is continuous.
- Undefined: one-shot playback.
  - A forward boundary at LAST_ADDR goes to PAUSED with rom_addr <= 0.
  - A reverse boundary at 0 goes to PAUSED with rom_addr <= LAST_ADDR.
  - The next play_pause restarts from that address.

Decomposition:
- Package tone_seq_pkg:
  - state encoding (PAUSED=0, PLAYING=1).
  - TEMPO_DEFAULT/STEP/MIN/MAX default constants.
  - 125 MHz cycles-per-ms constant.
- Sub-module tempo_ctrl: saturating tempo register with up/down pulses, parameterised by the same constants.
- Sequencer FSM, note counter and address logic stay in tone_sequencer.

Test Plan:
Bench parameters: LAST_ADDR=3, TEMPO_DEFAULT=10, STEP=2, MIN=4, MAX=16. ROM = {100,200,0,400}.
- Reset, no input, 50 cycles -> rom_addr=0, tone_period=0, playing=0 throughout.
- play_pause at cycle 0 -> playing=1 next cycle; tone_period=100 at cycle 2; rom_addr 0→1→2→3→0 every 10 cycles; tone_period 200 then 0 (rest) then 400, each 2 cycles after its address change.
- PLAYING at addr 1, reverse pulse -> next boundary gives addr 0, then 3. A pulse coinciding with a boundary steps directly to 0.
- tempo_down ×5 -> tempo saturates at 4; notes last 4 cycles. Then tempo_up ×10 -> tempo 16. A same-cycle up+down leaves tempo unchanged.
- play_pause on a boundary cycle -> rom_addr unchanged, tone_period=0 two cycles later; resume continues from the same addr/note_cnt.
- Without TONE_SEQ_LOOP_EN: forward boundary at addr 3 -> playing=0, rom_addr=0. With the macro: wraps and keeps playing.
- rst asserted mid-note at addr 2 -> rom_addr=0, tone_period=0, tempo=10 immediately (async).
